// File: rtl/dmem_lsu.sv
// dmem_lsu: MEM-stage load/store unit driving the data-memory RD/WR port.
// Ports: clk/rst_n; req_* request in (valid/ready, we, funct3, addr, wdata);
//        resp_* one-cycle response (valid, rdata, err); busy stall output;
//        mem_* memory side (RD, WR, addr, wdata, byte_en strobes; rdata in).
module dmem_lsu #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [2:0]            req_funct3,
    input  logic [DATA_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  resp_valid,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic                  resp_err,
    output logic                  busy,
    output logic                  mem_RD,
    output logic                  mem_WR,
    output logic [DATA_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic [3:0]            mem_byte_en,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        CAPTURE
    } state_t;

    state_t     state;
    logic [2:0] funct3_q;
    logic       we_q;

    logic                  legal;
    logic                  aligned;
    logic [3:0]            be_d;
    logic [DATA_WIDTH-1:0] wd_d;
    logic [7:0]            byte_sel;
    logic [15:0]           half_sel;
    logic [DATA_WIDTH-1:0] ld_data;

    assign req_ready = (state == IDLE);
    assign busy      = (state != IDLE);

    // Request decode: 011 and 11x never legal; 10x only for loads.
    always_comb begin
        legal   = (req_funct3[1:0] != 2'b11)
                & ~(req_funct3[2] & (req_we | req_funct3[1]));
        aligned = 1'b0;
        be_d    = 4'b0000;
        wd_d    = '0;
        case (req_funct3[1:0])
            2'b00: begin
                aligned = 1'b1;
                be_d    = 4'b0001 << req_addr[1:0];
                wd_d    = {24'b0, req_wdata[7:0]};
            end
            2'b01: begin
                aligned = ~req_addr[0];
                be_d    = req_addr[1] ? 4'b1100 : 4'b0011;
                wd_d    = {16'b0, req_wdata[15:0]};
            end
            default: begin
                aligned = (req_addr[1:0] == 2'b00);
                be_d    = 4'b1111;
                wd_d    = req_wdata;
            end
        endcase
    end

    // Load lane select and extension; funct3[2] marks the unsigned forms.
    always_comb begin
        byte_sel = mem_rdata[{mem_addr[1:0], 3'b000} +: 8];
        half_sel = mem_addr[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (funct3_q[1:0])
            2'b00:   ld_data = {{24{~funct3_q[2] & byte_sel[7]}}, byte_sel};
            2'b01:   ld_data = {{16{~funct3_q[2] & half_sel[15]}}, half_sel};
            default: ld_data = mem_rdata;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            funct3_q    <= 3'b000;
            we_q        <= 1'b0;
            resp_valid  <= 1'b0;
            resp_err    <= 1'b0;
            resp_rdata  <= '0;
            mem_RD      <= 1'b0;
            mem_WR      <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            mem_byte_en <= 4'b0000;
        end else begin
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            mem_RD     <= 1'b0;
            mem_WR     <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        if (legal && aligned) begin
                            mem_addr    <= req_addr;
                            mem_wdata   <= wd_d;
                            mem_byte_en <= be_d;
                            funct3_q    <= req_funct3;
                            we_q        <= req_we;
                            mem_RD      <= ~req_we;
                            mem_WR      <= req_we;
                            state       <= ACCESS;
                        end else begin
                            // Trap without touching memory.
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                            resp_rdata <= '0;
                        end
                    end
                end
                ACCESS: begin
                    if (we_q) begin
                        resp_valid <= 1'b1;
                        resp_rdata <= '0;
                        state      <= IDLE;
                    end else begin
                        state <= CAPTURE;
                    end
                end
                CAPTURE: begin
                    resp_valid <= 1'b1;
                    resp_rdata <= ld_data;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_lsu.sv
// tb_dmem_lsu: self-checking bench for dmem_lsu with a lane-packing
// data memory model and a byte-array reference model.
module tb_dmem_lsu;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        busy;
    logic        mem_RD;
    logic        mem_WR;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_byte_en;
    logic [31:0] mem_rdata;

    always #5 clk = ~clk;

    dmem_lsu #(.DATA_WIDTH(32)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_we(req_we),
        .req_funct3(req_funct3),
        .req_addr(req_addr),
        .req_wdata(req_wdata),
        .resp_valid(resp_valid),
        .resp_rdata(resp_rdata),
        .resp_err(resp_err),
        .busy(busy),
        .mem_RD(mem_RD),
        .mem_WR(mem_WR),
        .mem_addr(mem_addr),
        .mem_wdata(mem_wdata),
        .mem_byte_en(mem_byte_en),
        .mem_rdata(mem_rdata)
    );

    // Data memory: registered read; write packs low data bytes into enabled lanes.
    logic [31:0] mem [0:63];
    int wk;
    always @(posedge clk) begin
        if (mem_RD) mem_rdata <= mem[mem_addr[7:2]];
        if (mem_WR) begin
            wk = 0;
            for (int i = 0; i < 4; i++) begin
                if (mem_byte_en[i]) begin
                    mem[mem_addr[7:2]][8*i +: 8] <= mem_wdata[8*wk +: 8];
                    wk++;
                end
            end
        end
    end

    int rd_cnt = 0, wr_cnt = 0, resp_cnt = 0;
    bit both_seen = 1'b0;
    always @(negedge clk) begin
        if (mem_RD) rd_cnt++;
        if (mem_WR) wr_cnt++;
        if (resp_valid) resp_cnt++;
        if (mem_RD && mem_WR) both_seen = 1'b1;
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Reference: byte-addressed memory, little-endian, RV32I rules.
    logic [7:0] rmem [0:255];

    task automatic ref_op(input logic we, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] d, output logic err,
                          output logic [31:0] rd, output logic [3:0] be,
                          output logic [31:0] wd);
        int sz;
        logic [31:0] val;
        logic ok;
        sz = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
        ok = we ? (f3 inside {3'd0, 3'd1, 3'd2})
                : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        err = !ok || (a % sz != 0);
        rd = 0;
        be = 0;
        wd = (sz == 4) ? d : d & ((32'd1 << (8 * sz)) - 1);
        if (!err) begin
            be = 4'(((1 << sz) - 1) << (a % 4));
            if (we) begin
                for (int i = 0; i < sz; i++) rmem[(a + i) & 255] = d[8*i +: 8];
            end else begin
                val = 0;
                for (int i = 0; i < sz; i++)
                    val = val | (32'(rmem[(a + i) & 255]) << (8 * i));
                if (!f3[2] && sz < 4 && val[8*sz-1])
                    val = val - (32'd1 << (8 * sz));
                rd = val;
            end
        end
    endtask

    task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] d, output logic err,
                          output logic [31:0] rd, output logic [3:0] be,
                          output logic [31:0] wd, output int lat, output int strb);
        int r0, w0;
        @(negedge clk);
        req_valid = 1'b1;
        req_we = we;
        req_funct3 = f3;
        req_addr = a;
        req_wdata = d;
        r0 = rd_cnt;
        w0 = wr_cnt;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        be = mem_byte_en;
        wd = mem_wdata;
        lat = -1;
        err = 1'b0;
        rd = 32'hx;
        for (int n = 0; n < 6; n++) begin
            if (resp_valid) begin
                lat = n;
                err = resp_err;
                rd = resp_rdata;
                break;
            end
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        strb = (rd_cnt - r0) + (wr_cnt - w0);
    endtask

    task automatic check_txn(input string tag, input logic we, input logic [2:0] f3,
                             input logic [31:0] a, input logic [31:0] d,
                             input logic e_err, input logic [31:0] e_rd,
                             input logic [3:0] e_be, input logic [31:0] e_wd);
        logic err;
        logic [31:0] rd, wd;
        logic [3:0] be;
        int lat, strb;
        do_req(we, f3, a, d, err, rd, be, wd, lat, strb);
        chk({tag, " err"}, 32'(err), 32'(e_err));
        chk({tag, " rdata"}, rd, e_rd);
        chk({tag, " latency"}, lat, e_err ? 0 : (we ? 1 : 2));
        chk({tag, " strobes"}, strb, e_err ? 0 : 1);
        if (!e_err) chk({tag, " byte_en"}, 32'(be), 32'(e_be));
        if (!e_err && we) chk({tag, " wdata"}, wd, e_wd);
    endtask

    typedef struct packed {
        logic        we;
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] d;
        logic        e;
        logic [31:0] rd;
        logic [3:0]  be;
        logic [31:0] wd;
    } vec_t;

    vec_t tbl[$];

    initial begin
        #3000000;
        $display("FAIL global timeout");
        $fatal(1);
    end

    initial begin
        logic        e_err;
        logic [31:0] e_rd, e_wd, a, d;
        logic [3:0]  e_be;
        logic        we;
        logic [2:0]  f3;
        logic [4:0]  bp, rv;
        int          r0, rc;

        for (int i = 0; i < 64; i++) mem[i] = 32'h0;
        for (int i = 0; i < 256; i++) rmem[i] = 8'h0;

        tbl.push_back('{1'b1, 3'd2, 32'h10, 32'hDEADBEEF, 1'b0, 32'h0, 4'hF, 32'hDEADBEEF});
        tbl.push_back('{1'b0, 3'd2, 32'h10, 32'h0, 1'b0, 32'hDEADBEEF, 4'hF, 32'h0});
        tbl.push_back('{1'b1, 3'd0, 32'h21, 32'hA5, 1'b0, 32'h0, 4'h2, 32'hA5});
        tbl.push_back('{1'b0, 3'd0, 32'h21, 32'h0, 1'b0, 32'hFFFFFFA5, 4'h2, 32'h0});
        tbl.push_back('{1'b0, 3'd4, 32'h21, 32'h0, 1'b0, 32'h000000A5, 4'h2, 32'h0});
        tbl.push_back('{1'b1, 3'd1, 32'h32, 32'h8001, 1'b0, 32'h0, 4'hC, 32'h8001});
        tbl.push_back('{1'b0, 3'd1, 32'h32, 32'h0, 1'b0, 32'hFFFF8001, 4'hC, 32'h0});
        tbl.push_back('{1'b0, 3'd5, 32'h32, 32'h0, 1'b0, 32'h00008001, 4'hC, 32'h0});
        tbl.push_back('{1'b0, 3'd2, 32'h30, 32'h0, 1'b0, 32'h80010000, 4'hF, 32'h0});
        tbl.push_back('{1'b1, 3'd0, 32'h23, 32'h12345677, 1'b0, 32'h0, 4'h8, 32'h77});
        tbl.push_back('{1'b0, 3'd4, 32'h23, 32'h0, 1'b0, 32'h77, 4'h8, 32'h0});
        tbl.push_back('{1'b0, 3'd2, 32'h20, 32'h0, 1'b0, 32'h7700A500, 4'hF, 32'h0});
        tbl.push_back('{1'b0, 3'd2, 32'h41, 32'h0, 1'b1, 32'h0, 4'h0, 32'h0});
        tbl.push_back('{1'b0, 3'd1, 32'h43, 32'h0, 1'b1, 32'h0, 4'h0, 32'h0});
        tbl.push_back('{1'b1, 3'd2, 32'h42, 32'h0, 1'b1, 32'h0, 4'h0, 32'h0});
        tbl.push_back('{1'b0, 3'd3, 32'h40, 32'h0, 1'b1, 32'h0, 4'h0, 32'h0});
        tbl.push_back('{1'b1, 3'd4, 32'h40, 32'h0, 1'b1, 32'h0, 4'h0, 32'h0});

        rst_n = 1'b0;
        req_valid = 1'b0;
        req_we = 1'b0;
        req_funct3 = 3'd0;
        req_addr = 32'h0;
        req_wdata = 32'h0;
        repeat (2) @(negedge clk);
        chk("reset req_ready", 32'(req_ready), 32'd1);
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset resp", {29'd0, resp_valid, resp_err, mem_RD | mem_WR}, 32'd0);
        chk("reset resp_rdata", resp_rdata, 32'h0);
        chk("reset mem_addr", mem_addr, 32'h0);
        chk("reset mem_wdata", mem_wdata, 32'h0);
        chk("reset byte_en", 32'(mem_byte_en), 32'h0);
        rst_n = 1'b1;

        foreach (tbl[i]) begin
            ref_op(tbl[i].we, tbl[i].f3, tbl[i].a, tbl[i].d, e_err, e_rd, e_be, e_wd);
            check_txn($sformatf("vec%0d", i), tbl[i].we, tbl[i].f3, tbl[i].a, tbl[i].d,
                      tbl[i].e, tbl[i].rd, tbl[i].be, tbl[i].wd);
        end

        for (int i = 0; i < 150; i++) begin
            we = 1'($urandom % 2);
            f3 = 3'($urandom % 8);
            a = 32'h80 + ($urandom % 128);
            if ($urandom % 2 == 0) a[1:0] = 2'b00;
            d = $urandom;
            ref_op(we, f3, a, d, e_err, e_rd, e_be, e_wd);
            check_txn($sformatf("rnd%0d", i), we, f3, a, d, e_err, e_rd, e_be, e_wd);
        end

        // Request held through busy cycles is taken once.
        check_txn("sw70", 1'b1, 3'd2, 32'h70, 32'hCAFEF00D, 1'b0, 32'h0, 4'hF, 32'hCAFEF00D);
        @(negedge clk);
        r0 = rd_cnt;
        req_valid = 1'b1;
        req_we = 1'b0;
        req_funct3 = 3'd2;
        req_addr = 32'h70;
        @(posedge clk);
        #1;
        chk("hold ready while busy", 32'(req_ready), 32'd0);
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("hold resp_valid", 32'(resp_valid), 32'd1);
        chk("hold rdata", resp_rdata, 32'hCAFEF00D);
        repeat (3) @(negedge clk);
        chk("hold single capture", rd_cnt - r0, 32'd1);

        // Back-to-back SW then LW with request held continuously.
        @(negedge clk);
        req_valid = 1'b1;
        req_we = 1'b1;
        req_funct3 = 3'd2;
        req_addr = 32'h74;
        req_wdata = 32'h0BADC0DE;
        @(posedge clk);
        #1;
        bp[4] = busy;
        rv[4] = resp_valid;
        @(negedge clk);
        req_we = 1'b0;
        req_wdata = 32'h0;
        @(posedge clk);
        #1;
        bp[3] = busy;
        rv[3] = resp_valid;
        @(posedge clk);
        #1;
        bp[2] = busy;
        rv[2] = resp_valid;
        @(negedge clk);
        req_valid = 1'b0;
        @(posedge clk);
        #1;
        bp[1] = busy;
        rv[1] = resp_valid;
        @(posedge clk);
        #1;
        bp[0] = busy;
        rv[0] = resp_valid;
        chk("b2b busy pattern", 32'(bp), 32'b10110);
        chk("b2b resp pattern", 32'(rv), 32'b01001);
        chk("b2b load data", resp_rdata, 32'h0BADC0DE);

        // Async reset during a store's access cycle.
        @(negedge clk);
        req_valid = 1'b1;
        req_we = 1'b1;
        req_funct3 = 3'd2;
        req_addr = 32'h50;
        req_wdata = 32'h12345678;
        @(posedge clk);
        #2;
        req_valid = 1'b0;
        chk("pre-reset mem_WR", 32'(mem_WR), 32'd1);
        rc = resp_cnt;
        rst_n = 1'b0;
        #1;
        chk("mid reset strobes", {30'd0, mem_WR, mem_RD}, 32'd0);
        chk("mid reset ready/busy", {30'd0, req_ready, busy}, 32'b10);
        chk("mid reset mem_addr", mem_addr, 32'h0);
        chk("mid reset byte_en", 32'(mem_byte_en), 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("no resp after reset", resp_cnt - rc, 32'd0);
        chk("ready after reset", 32'(req_ready), 32'd1);
        check_txn("post-reset lw", 1'b0, 3'd2, 32'h10, 32'h0, 1'b0, 32'hDEADBEEF, 4'hF, 32'h0);

        chk("RD and WR never together", 32'(both_seen), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
